ahb_sram_bridge: RTL and testbench

- Parametrised AHB-Lite slave that bridges single beats and bursts to a synchronous single-port SRAM macro of configurable width, depth and read latency.
- Successor to the fixed 32-bit AHB SRAM controller. It adds posted writes through a one-entry write buffer, programmable read wait states, byte-lane strobes, and address/size error checking.
- Sits behind the AHB decoder/mux. The SRAM macro is external to this block.

---
 rtl/ahb_sram_bridge.sv | 181 ++++++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_bridge.sv
// rtl/ahb_sram_bridge.sv - AHB-Lite slave bridging beats to a synchronous single-port SRAM
//
// Purpose: decodes AHB-Lite transfers inside a DEPTH*BYTES byte window at
// BASE_ADDR. Writes are posted through a one-entry buffer and complete with no
// wait states. Reads stall for RD_LAT cycles, plus one more when a posted write
// must drain first. Out-of-window, oversize and misaligned transfers are errors
// and never touch the SRAM.
// Optional: define AHB_SRAM_ERR_RESP_EN to give errored transfers the
// two-cycle ERROR response. Without it they complete OKAY with no wait states.
//
// Ports:
//   hclk, hrst                  clock, async active-high reset
//   hsel, htrans, hburst, hsize AHB address-phase control (hburst ignored)
//   hwrite, haddr, hwdata       direction, byte address, write data
//   hready_in                   bus ready
//   hready_out, hresp, hrdata   slave response
//   sram_cs, sram_we, sram_be   SRAM strobes and byte enables
//   sram_addr, sram_wdata       SRAM word address and write data
//   sram_rdata                  SRAM read data, RD_LAT cycles after a read strobe
module ahb_sram_bridge #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          RD_LAT    = 1,
  localparam int         BYTES     = DATA_W / 8,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready_in,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [BYTES-1:0]  sram_be,
  output logic [AW-1:0]     sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int         BL       = $clog2(BYTES);
  localparam logic [32:0] WIN     = 33'(DEPTH) * 33'(BYTES);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISS,
    RD_WAIT
`ifdef AHB_SRAM_ERR_RESP_EN
    , ERR1,
    ERR2
`endif
  } state_t;

  state_t             state, state_n, acc_state;
  logic [1:0]         cnt;
  logic               wr_dp;     // write data phase in progress
  logic [AW-1:0]      ap_addr;   // word index of the last accepted transfer
  logic [BYTES-1:0]   ap_be;
  logic               buf_valid;
  logic [AW-1:0]      buf_addr;
  logic [BYTES-1:0]   buf_be;
  logic [DATA_W-1:0]  buf_data;

  logic [31:0]        off;
  logic [7:0]         size_mask;
  logic               addr_err, take, rd_strobe, read_done;
  logic [BYTES-1:0]   lane_be;
  logic               unused_bits;

  assign unused_bits = ^{hburst, htrans[0]};

  // Address-phase decode. BASE_ADDR is window aligned, so alignment of haddr
  // equals alignment of the window offset.
  assign off       = haddr - BASE_ADDR;
  assign size_mask = (8'd1 << hsize) - 8'd1;
  assign addr_err  = !((haddr >= BASE_ADDR) && ({1'b0, off} < WIN))
                   || (hsize > 3'(BL))
                   || (|(haddr[7:0] & size_mask));

  always_comb begin
    lane_be = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i >= int'(haddr[BL-1:0]) && i < int'(haddr[BL-1:0]) + (1 << hsize))
        lane_be[i] = 1'b1;
    end
  end

  assign read_done = (state == RD_WAIT) && (cnt == 2'd0);

`ifdef AHB_SRAM_ERR_RESP_EN
  assign hready_out = (state == IDLE) || read_done || (state == ERR2);
  assign hresp      = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
`else
  assign hready_out = (state == IDLE) || read_done;
  assign hresp      = 2'b00;
`endif

  // Only address phases seen while this slave is ready can be accepted.
  assign take = hsel && hready_in && htrans[1] && hready_out;

  always_comb begin
    acc_state = IDLE;
    if (take) begin
      if (addr_err) begin
`ifdef AHB_SRAM_ERR_RESP_EN
        acc_state = ERR1;
`else
        acc_state = IDLE;
`endif
      end else if (!hwrite) begin
        acc_state = RD_ISS;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc_state;
      RD_ISS:  if (!buf_valid) state_n = RD_WAIT;  // posted write drains first
      RD_WAIT: if (cnt == 2'd0) state_n = acc_state;
`ifdef AHB_SRAM_ERR_RESP_EN
      ERR1:    state_n = ERR2;
      ERR2:    state_n = acc_state;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      wr_dp     <= 1'b0;
      ap_addr   <= '0;
      ap_be     <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_be    <= '0;
      buf_data  <= '0;
    end else begin
      state <= state_n;
      wr_dp <= take && hwrite && !addr_err;
      if (take && !addr_err) begin
        ap_addr <= off[AW+BL-1:BL];
        ap_be   <= lane_be;
      end
      // A load in the drain cycle simply replaces the entry being written out.
      if (wr_dp) begin
        buf_valid <= 1'b1;
        buf_addr  <= ap_addr;
        buf_be    <= ap_be;
        buf_data  <= hwdata;
      end else begin
        buf_valid <= 1'b0;
      end
      if (state == RD_ISS && !buf_valid)
        cnt <= CNT_INIT;
      else if (state == RD_WAIT && cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

  assign rd_strobe  = (state == RD_ISS) && !buf_valid;
  assign hrdata     = read_done ? sram_rdata : '0;
  assign sram_cs    = buf_valid || rd_strobe;
  assign sram_we    = buf_valid;
  assign sram_be    = buf_valid ? buf_be   : (rd_strobe ? '1 : '0);
  assign sram_addr  = buf_valid ? buf_addr : (rd_strobe ? ap_addr : '0);
  assign sram_wdata = buf_valid ? buf_data : '0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb/tb_ahb_sram_bridge.sv - self-checking bench for ahb_sram_bridge
module tb_ahb_sram_bridge;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        hsel, hwrite, hready_in, tgt;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata;

  logic        hsel1, ho1, cs1, we1;
  logic [1:0]  hresp1;
  logic [31:0] hrdata1, wdata1, rdata1;
  logic [3:0]  be1;
  logic [11:0] addr1;
  logic        hsel3, ho3, cs3, we3;
  logic [1:0]  hresp3;
  logic [31:0] hrdata3, wdata3, rdata3;
  logic [3:0]  be3;
  logic [11:0] addr3;

  logic        ho, cs, we;
  logic [1:0]  hresp;
  logic [31:0] hrdata, wd;
  logic [3:0]  be;
  logic [11:0] sa;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  assign hsel1  = hsel & ~tgt;
  assign hsel3  = hsel & tgt;
  assign ho     = tgt ? ho3     : ho1;
  assign hresp  = tgt ? hresp3  : hresp1;
  assign hrdata = tgt ? hrdata3 : hrdata1;
  assign cs     = tgt ? cs3     : cs1;
  assign we     = tgt ? we3     : we1;
  assign be     = tgt ? be3     : be1;
  assign sa     = tgt ? addr3   : addr1;
  assign wd     = tgt ? wdata3  : wdata1;

  ahb_sram_bridge #(.RD_LAT(1)) u1 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel1), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready_in(hready_in), .hready_out(ho1), .hresp(hresp1), .hrdata(hrdata1),
    .sram_cs(cs1), .sram_we(we1), .sram_be(be1), .sram_addr(addr1),
    .sram_wdata(wdata1), .sram_rdata(rdata1));

  ahb_sram_bridge #(.RD_LAT(3)) u3 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel3), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready_in(hready_in), .hready_out(ho3), .hresp(hresp3), .hrdata(hrdata3),
    .sram_cs(cs3), .sram_we(we3), .sram_be(be3), .sram_addr(addr3),
    .sram_wdata(wdata3), .sram_rdata(rdata3));

  // SRAM models: latency 1 and latency 3
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] rp1;
  logic [31:0] rp3 [0:2];
  int          wcount1 = 0;

  always @(posedge hclk) begin
    if (cs1 && we1) begin
      for (int b = 0; b < 4; b++)
        if (be1[b]) mem1[addr1][8*b +: 8] <= wdata1[8*b +: 8];
      wcount1 <= wcount1 + 1;
    end
    rp1 <= (cs1 && !we1) ? mem1[addr1] : 32'h0;
  end
  assign rdata1 = rp1;

  always @(posedge hclk) begin
    if (cs3 && we3)
      for (int b = 0; b < 4; b++)
        if (be3[b]) mem3[addr3][8*b +: 8] <= wdata3[8*b +: 8];
    rp3[0] <= (cs3 && !we3) ? mem3[addr3] : 32'h0;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rdata3 = rp3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
  endtask

  typedef struct {
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    logic [3:0]  be;
    logic [11:0] widx;
  } vec_t;

  vec_t vt [8];

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, guard, wc_snap;
    logic [31:0] eaddr [2];
    logic [2:0]  esize [2];
    logic        e_rdy_b;
    logic [1:0]  e_resp;

    vt[0] = '{3'd2, 32'h1000_0010, 32'h1234_5678, 1'b0, 4'hF, 12'h004};
    vt[1] = '{3'd0, 32'h1000_0013, 32'hAB00_0000, 1'b0, 4'h8, 12'h004};
    vt[2] = '{3'd1, 32'h1000_0006, 32'hCAFE_0000, 1'b0, 4'hC, 12'h001};
    vt[3] = '{3'd0, 32'h1000_3FFF, 32'h5A00_0000, 1'b0, 4'h8, 12'hFFF};
    vt[4] = '{3'd2, 32'h1000_4000, 32'h1111_1111, 1'b1, 4'h0, 12'h000};
    vt[5] = '{3'd2, 32'h0FFF_FFFC, 32'h2222_2222, 1'b1, 4'h0, 12'h000};
    vt[6] = '{3'd3, 32'h1000_0020, 32'h3333_3333, 1'b1, 4'h0, 12'h000};
    vt[7] = '{3'd1, 32'h1000_0011, 32'h4444_4444, 1'b1, 4'h0, 12'h000};

    e_rdy_b = ~ERR_EN;
    e_resp  = ERR_EN ? 2'b01 : 2'b00;

    hrst = 1'b1; hsel = 1'b0; htrans = 2'b00; hburst = 3'd0; hsize = 3'd0;
    hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0; hready_in = 1'b1; tgt = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hready", ho1, 1); chk("rst_hresp", hresp1, 0); chk("rst_hrdata", hrdata1, 0);
    chk("rst_cs", cs1, 0); chk("rst_we", we1, 0); chk("rst_be", be1, 0);
    chk("rst_addr", addr1, 0); chk("rst_wdata", wdata1, 0);
    chk("rst_hready3", ho3, 1); chk("rst_cs3", cs3, 0);
    hrst = 1'b0;

    // Table-driven single writes on the latency-1 instance
    for (int i = 0; i < 8; i++) begin
      tick;
      addr_phase(1'b1, vt[i].addr, vt[i].size);
      tick;
      htrans = 2'b00; hwdata = vt[i].data;
      @(negedge hclk);
      chk("wr_dp_hready", ho, vt[i].err ? e_rdy_b : 1'b1);
      chk("wr_dp_hresp", hresp, vt[i].err ? e_resp : 2'b00);
      chk("wr_dp_cs", cs, 0);
      tick;
      @(negedge hclk);
      chk("wr_cs", cs, !vt[i].err);
      chk("wr_we", we, !vt[i].err);
      chk("wr_be", be, vt[i].be);
      chk("wr_addr", sa, vt[i].widx);
      chk("wr_wdata", wd, vt[i].err ? 32'h0 : vt[i].data);
      chk("wr_c_hready", ho, 1);
      chk("wr_c_hresp", hresp, vt[i].err ? e_resp : 2'b00);
      tick;
      hsel = 1'b0;
    end

    // Byte write then back-to-back word read (RD_LAT=1), buffer pending
    tick;
    addr_phase(1'b1, 32'h1000_0013, 3'd0);
    tick;
    hwdata = 32'hAB00_0000;
    addr_phase(1'b0, 32'h1000_0010, 3'd2);
    @(negedge hclk);
    chk("raw_dp_hready", ho, 1);
    tick;
    htrans = 2'b00;
    @(negedge hclk);
    chk("raw_drain_cs", cs, 1); chk("raw_drain_we", we, 1); chk("raw_drain_be", be, 4'h8);
    chk("raw_wait_hrdata", hrdata, 0);
    waits = ho ? 0 : 1; guard = 0;
    while (!ho && guard < 20) begin
      tick; @(negedge hclk); guard++;
      if (!ho) waits++;
    end
    chk("raw_done", ho, 1);
    chk("raw_waits", waits, 2);
    chk("raw_hrdata", hrdata, 32'hAB34_5678);
    tick;
    @(negedge hclk);
    chk("raw_hrdata_after", hrdata, 0);

    // RD_LAT=3 halfword read, no pending write
    tgt = 1'b1;
    tick;
    addr_phase(1'b1, 32'h1000_0010, 3'd2);
    tick;
    hwdata = 32'hDEAD_BEEF; htrans = 2'b00;
    tick; tick;
    addr_phase(1'b0, 32'h1000_0012, 3'd1);
    tick;
    htrans = 2'b00;
    @(negedge hclk);
    chk("lat3_rd_cs", cs, 1); chk("lat3_rd_we", we, 0); chk("lat3_rd_addr", sa, 12'h004);
    waits = ho ? 0 : 1; guard = 0;
    while (!ho && guard < 20) begin
      tick; @(negedge hclk); guard++;
      if (!ho) waits++;
    end
    chk("lat3_done", ho, 1);
    chk("lat3_waits", waits, 3);
    chk("lat3_hrdata", hrdata, 32'hDEAD_BEEF);
    tick;
    hsel = 1'b0; tgt = 1'b0;

    // Error reads: out of window, misaligned halfword
    eaddr[0] = 32'h1000_9FFF; esize[0] = 3'd0;
    eaddr[1] = 32'h1000_0011; esize[1] = 3'd1;
    for (int i = 0; i < 2; i++) begin
      tick;
      addr_phase(1'b0, eaddr[i], esize[i]);
      tick;
      htrans = 2'b00;
      @(negedge hclk);
      chk("err_b_hready", ho, e_rdy_b); chk("err_b_hresp", hresp, e_resp);
      chk("err_b_cs", cs, 0); chk("err_b_hrdata", hrdata, 0);
      tick;
      @(negedge hclk);
      chk("err_c_hready", ho, 1); chk("err_c_hresp", hresp, e_resp); chk("err_c_cs", cs, 0);
      tick;
    end

    // Handshake gating: hready_in low, BUSY, hsel low
    for (int i = 0; i < 3; i++) begin
      tick;
      addr_phase(1'b0, 32'h1000_0010, 3'd2);
      if (i == 0) hready_in = 1'b0;
      if (i == 1) htrans = 2'b01;
      if (i == 2) hsel = 1'b0;
      tick;
      htrans = 2'b00; hready_in = 1'b1; hsel = 1'b1;
      @(negedge hclk);
      chk("gate_hready", ho, 1); chk("gate_hresp", hresp, 0); chk("gate_cs", cs, 0);
      tick;
      @(negedge hclk);
      chk("gate_cs_late", cs, 0);
    end

    // Reset while a posted write is draining ahead of a read
    tick;
    addr_phase(1'b1, 32'h1000_0020, 3'd2);
    tick;
    hwdata = 32'h55AA_55AA;
    addr_phase(1'b0, 32'h1000_0020, 3'd2);
    tick;
    htrans = 2'b00;
    @(negedge hclk);
    chk("rst_mid_cs_before", cs, 1); chk("rst_mid_hready_before", ho, 0);
    wc_snap = wcount1;
    #1 hrst = 1'b1;
    #1;
    chk("rst_mid_hready", ho, 1); chk("rst_mid_hresp", hresp, 0); chk("rst_mid_cs", cs, 0);
    @(posedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      chk("rst_post_cs", cs, 0);
    end
    chk("rst_no_write", wcount1, wc_snap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
